lift_request_scheduler: RTL
===========================

Name: lift_request_scheduler

Overview:
- Upstream request/dispatch stage for the one-hot lift floor tracker.
- Latches floor-call buttons into a pending mask and runs a SCAN (up/down sweep) FSM against the tracker's current-floor output.
- Drives the tracker's one-hot target-floor input and holds the door open for a fixed dwell at each served floor.
- One clock domain; all outputs are registered.

Parameters:
- NUM_FLOORS, 4, number of floors; width of every floor vector; one-hot, bit 0 = ground floor.
- DOOR_CYCLES, 8, clk cycles the door stays open per stop; legal range 2 to 255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req_btn  input  NUM_FLOORS  floor-call buttons; level-sampled each cycle; any bit high registers a request.
- cur_floor  input  NUM_FLOORS  current floor, one-hot, from the floor tracker output.
- target_floor  output  NUM_FLOORS  one-hot target, fed to the floor tracker's floor input.
- pending  output  NUM_FLOORS  outstanding request mask.
- door_open  output  1  high while dwelling at a served floor.
- dir_up  output  1  last or current sweep direction; 1 = up, 0 = down.
- floor_err  output  1  high for any cycle in which cur_floor is not exactly one-hot.

Behaviour:
- Reset (synchronous, rst high at an edge):
  - state = IDLE, pending = 0, target_floor = 1 (ground floor), door_open = 0, dir_up = 1, floor_err = 0, dwell counter = 0.
  - Reset mid-move or mid-dwell discards all requests.
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Latency:
  - A button high at edge k sets pending after edge k.
  - The FSM acts on registered pending, so state and target_floor update after edge k+1.
- Definitions: "above" = pending bits at indices greater than the cur_floor index; "below" = pending bits at lower indices.
- IDLE:
  - target_floor = cur_floor.
  - If the pending bit at cur_floor is set, go to DOOR.
  - Else if any above, go to MOVE_UP and set dir_up = 1.
  - Else if any below, go to MOVE_DOWN and set dir_up = 0.
  - Else stay in IDLE.
- MOVE_UP:
  - target_floor = lowest pending bit above cur_floor.
  - When cur_floor equals that bit, go to DOOR.
  - If pending above becomes empty, go to IDLE.
- MOVE_DOWN: mirror of MOVE_UP; target_floor = highest pending bit below cur_floor.
- DOOR entry:
  - door_open = 1 and the dwell counter loads DOOR_CYCLES-1.
  - The pending bit at cur_floor clears on the entry edge.
  - target_floor = cur_floor throughout DOOR.
- DOOR, while counting down:
  - A new press of the current floor is absorbed: its bit is not set, and the counter reloads DOOR_CYCLES-1.
- DOOR, when the counter reaches 0: door_open = 0, then:
  - if dir_up = 1 and pending above, go to MOVE_UP;
  - else if pending below, go to MOVE_DOWN (dir_up = 0);
  - else if pending above, go to MOVE_UP (dir_up = 1);
  - else go to IDLE.
- Dwell length: door_open is high for exactly DOOR_CYCLES consecutive cycles when no re-press occurs.
- Simultaneous events:
  - A set and a clear of the same pending bit on one edge resolve to clear, i.e. it is served.
  - Presses of other floors are always latched.
- Invalid cur_floor (zero or more than one bit set):
  - floor_err = 1; FSM state, target_floor and the dwell counter hold.
  - Pending still latches new presses.
- Boundaries:
  - Top floor pressed while at the top floor is served in place (DOOR).
  - No wrap-around: MOVE_UP never targets a floor below cur_floor.
  - A request at ground while sweeping up waits for the sweep to finish.

Optional Feature:
- Macro: LIFT_EMERGENCY_EN.
- Defined:
  - Adds input port estop (1 bit) and state HALT.
  - estop high at any edge, from any state: go to HALT, clear pending, target_floor = cur_floor, door_open = 1, dwell counter = 0.
  - Button presses are ignored while estop is high.
  - When estop falls, go to IDLE with door_open = 0.
  - rst has priority over estop.
- Undefined: no estop port and no HALT state; behaviour exactly as above.

Test Plan:
- Reset: rst high 2 cycles, cur_floor = 0001 → target_floor = 0001, pending = 0000, door_open = 0, dir_up = 1.
- Single call: at floor 0001, pulse req_btn = 0100 for 1 cycle → pending = 0100 next cycle; MOVE_UP with target_floor = 0100 one cycle later; step cur_floor 0010 → 0100 → door_open high for exactly 8 cycles; pending = 0000; then IDLE.
- Sweep order: at floor 0001, press 1000 and 0010 in the same cycle → targets 0010 first (dwell), then 1000; a press of 0001 during the up-sweep is served only after the 1000 stop, with dir_up = 0.
- Door re-press: in DOOR at 0100, press 0100 at dwell cycle 5 → dwell restarts, door_open high 5+8 = 13 cycles total, pending bit stays 0.
- Invalid floor: drive cur_floor = 0110 during MOVE_UP → floor_err = 1, target_floor unchanged; a press of 0001 is still latched into pending; restoring 0100 resumes normal operation.
- LIFT_EMERGENCY_EN: pending = 1010, estop high → pending = 0000, door_open = 1, target_floor = cur_floor; estop low → IDLE, door_open = 0.

Source files
------------

// File: rtl/lift_request_scheduler.sv
// SCAN request scheduler feeding a one-hot lift floor tracker.
// Optional emergency stop via LIFT_EMERGENCY_EN (adds estop port, HALT state).
module lift_request_scheduler #(
  parameter int NUM_FLOORS  = 4,
  parameter int DOOR_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef LIFT_EMERGENCY_EN
  input  logic                  estop,
`endif
  input  logic [NUM_FLOORS-1:0] req_btn,
  input  logic [NUM_FLOORS-1:0] cur_floor,
  output logic [NUM_FLOORS-1:0] target_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  door_open,
  output logic                  dir_up,
  output logic                  floor_err
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    MOVE_UP   = 3'd1,
    MOVE_DOWN = 3'd2,
`ifdef LIFT_EMERGENCY_EN
    HALT      = 3'd4,
`endif
    DOOR      = 3'd3
  } state_t;

  localparam logic [7:0] DWELL = 8'(DOOR_CYCLES - 1);

  state_t state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [NUM_FLOORS-1:0] tgt_n, set_m, clr_m;
  logic door_n, up_n, valid;
  logic [NUM_FLOORS-1:0] below_m, above, below, here;
  logic [NUM_FLOORS-1:0] lo_above, hi_below;

  function automatic logic [NUM_FLOORS-1:0] msb(
    input logic [NUM_FLOORS-1:0] x
  );
    msb = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (x[i]) begin
        msb    = '0;
        msb[i] = 1'b1;
      end
    end
  endfunction

  assign valid    = $onehot(cur_floor);
  assign below_m  = cur_floor - 1'b1;
  assign here     = pending & cur_floor;
  assign below    = pending & below_m;
  assign above    = pending & ~(below_m | cur_floor);
  assign lo_above = above & (~above + 1'b1);
  assign hi_below = msb(below);

  // next-state, target, dwell and request-mask decisions
  always_comb begin
    state_n = state;
    tgt_n   = target_floor;
    door_n  = door_open;
    up_n    = dir_up;
    cnt_n   = cnt;
    set_m   = req_btn;
    clr_m   = '0;
`ifdef LIFT_EMERGENCY_EN
    if (estop) begin
      state_n = HALT;
      tgt_n   = cur_floor;
      door_n  = 1'b1;
      cnt_n   = '0;
      set_m   = '0;
      clr_m   = '1;
    end else if (state == HALT) begin
      state_n = IDLE;
      tgt_n   = cur_floor;
      door_n  = 1'b0;
    end else
`endif
    if (valid) begin
      unique case (state)
        IDLE: begin
          tgt_n = cur_floor;
          if (|here) begin
            state_n = DOOR;
            door_n  = 1'b1;
            cnt_n   = DWELL;
            clr_m   = cur_floor;
          end else if (|above) begin
            state_n = MOVE_UP;
            up_n    = 1'b1;
            tgt_n   = lo_above;
          end else if (|below) begin
            state_n = MOVE_DOWN;
            up_n    = 1'b0;
            tgt_n   = hi_below;
          end
        end
        MOVE_UP: begin
          if (|here) begin
            state_n = DOOR;
            door_n  = 1'b1;
            cnt_n   = DWELL;
            clr_m   = cur_floor;
            tgt_n   = cur_floor;
          end else if (|above) begin
            tgt_n = lo_above;
          end else begin
            state_n = IDLE;
            tgt_n   = cur_floor;
          end
        end
        MOVE_DOWN: begin
          if (|here) begin
            state_n = DOOR;
            door_n  = 1'b1;
            cnt_n   = DWELL;
            clr_m   = cur_floor;
            tgt_n   = cur_floor;
          end else if (|below) begin
            tgt_n = hi_below;
          end else begin
            state_n = IDLE;
            tgt_n   = cur_floor;
          end
        end
        DOOR: begin
          tgt_n = cur_floor;
          set_m = req_btn & ~cur_floor;
          if (|(req_btn & cur_floor)) begin
            cnt_n = DWELL;
          end else if (cnt != '0) begin
            cnt_n = cnt - 8'd1;
          end else begin
            door_n = 1'b0;
            if (dir_up && |above) begin
              state_n = MOVE_UP;
              tgt_n   = lo_above;
            end else if (|below) begin
              state_n = MOVE_DOWN;
              up_n    = 1'b0;
              tgt_n   = hi_below;
            end else if (|above) begin
              state_n = MOVE_UP;
              up_n    = 1'b1;
              tgt_n   = lo_above;
            end else begin
              state_n = IDLE;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // registered state and outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pending      <= '0;
      target_floor <= NUM_FLOORS'(1);
      door_open    <= 1'b0;
      dir_up       <= 1'b1;
      floor_err    <= 1'b0;
      cnt          <= '0;
    end else begin
      state        <= state_n;
      pending      <= (pending | set_m) & ~clr_m;
      target_floor <= tgt_n;
      door_open    <= door_n;
      dir_up       <= up_n;
      floor_err    <= ~valid;
      cnt          <= cnt_n;
    end
  end

endmodule
